voting_machine: RTL and testbench

VOTING_MACHINE -- requirements
Module: voting_machine

---
 rtl/voting_pkg.sv | 15 +
 rtl/voting_press_detect.sv | 33 +++
 rtl/voting_machine.sv | 89 ++++++++
 tb/tb_voting_machine.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/voting_pkg.sv
// Shared definitions for the voting machine.
// Holds the default counter width, the candidate count, the saturation value
// and the two poll states.
package voting_pkg;

    localparam int CNT_W   = 6;
    localparam int N_CAND  = 3;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    // Poll states. Kept as plain constants so older tools that cannot take
    // enum-typed ports still compile this package.
    localparam logic [0:0] VOTING = 1'b0;
    localparam logic [0:0] CLOSED = 1'b1;

endpackage

// File: rtl/voting_press_detect.sv
// press_detect: one-cycle press pulse from a level button.
// Ports:
//   clk     - clock, rising edge
//   rst     - synchronous active-high reset, clears the history bit
//   btn_i   - button level, high = pressed
//   press_o - high in the cycle where btn_i is 1 and its previous sample was 0
module press_detect (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic press_o
);

    logic hist_q;
    logic hist_d;

    always_comb begin
        hist_d = btn_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hist_q <= 1'b0;
        end else begin
            hist_q <= hist_d;
        end
    end

    // History clears during reset, so a button held across reset release
    // produces a press on the first normal edge.
    assign press_o = btn_i & ~hist_q;

endmodule

// File: rtl/voting_machine.sv
// voting_machine: three-candidate vote counter with a close-poll request.
// Each button press adds one vote to its candidate (saturating). A cycle with
// more than one press is discarded. Tallies stay hidden (outputs 0) while
// voting and are published from registers once the poll is closed.
// Ports:
//   clk                 - clock, rising edge
//   rst                 - synchronous active-high reset (highest priority)
//   i_candidate_1..3    - vote buttons, level, high = pressed
//   i_voting_over       - close-poll request, level
//   o_count1..3         - published tallies, 0 while voting
module voting_machine #(
    parameter int CNT_W  = 6,
    parameter int N_CAND = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_candidate_1,
    input  logic             i_candidate_2,
    input  logic             i_candidate_3,
    input  logic             i_voting_over,
    output logic [CNT_W-1:0] o_count1,
    output logic [CNT_W-1:0] o_count2,
    output logic [CNT_W-1:0] o_count3
);

    import voting_pkg::*;

    localparam logic [CNT_W-1:0] SAT = '1;

    logic [N_CAND-1:0] btn;
    logic [N_CAND-1:0] press;
    logic              single_press;

    logic [0:0]                   state_q, state_d;
    logic [N_CAND-1:0][CNT_W-1:0] cnt_q,   cnt_d;
    logic [N_CAND-1:0][CNT_W-1:0] out_q,   out_d;

    assign btn = {i_candidate_3, i_candidate_2, i_candidate_1};

    for (genvar g = 0; g < N_CAND; g++) begin : g_pd
        press_detect u_pd (
            .clk     (clk),
            .rst     (rst),
            .btn_i   (btn[g]),
            .press_o (press[g])
        );
    end

    // Exactly one bit set: nonzero and clearing the lowest set bit leaves 0.
    assign single_press = (press != '0) &&
                          ((press & (press - N_CAND'(1))) == '0);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (state_q == VOTING) begin
            // Closing wins over a press in the same cycle.
            if (i_voting_over) begin
                state_d = CLOSED;
            end else if (single_press) begin
                for (int i = 0; i < N_CAND; i++) begin
                    if (press[i] && (cnt_q[i] != SAT)) begin
                        cnt_d[i] = cnt_q[i] + CNT_W'(1);
                    end
                end
            end
        end
        // Output register follows the next state so tallies appear on the
        // same edge that closes the poll.
        out_d = (state_d == CLOSED) ? cnt_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= VOTING;
            cnt_q   <= '0;
            out_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
        end
    end

    assign o_count1 = out_q[0];
    assign o_count2 = out_q[1];
    assign o_count3 = out_q[2];

endmodule

// File: tb/tb_voting_machine.sv
// Self-checking bench for voting_machine. Inputs change on the falling edge,
// outputs are sampled on the falling edge before inputs change. Expected
// tallies are pushed to a scoreboard queue and popped when outputs are read.
module tb_voting_machine;

    logic       clk = 1'b0;
    logic       rst;
    logic       c1, c2, c3, vo;
    logic [5:0] o1, o2, o3;

    typedef struct {
        logic [5:0] e1;
        logic [5:0] e2;
        logic [5:0] e3;
    } exp_t;

    exp_t sb_q[$];
    exp_t e;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    voting_machine #(.CNT_W(6), .N_CAND(3)) dut (
        .clk           (clk),
        .rst           (rst),
        .i_candidate_1 (c1),
        .i_candidate_2 (c2),
        .i_candidate_3 (c3),
        .i_voting_over (vo),
        .o_count1      (o1),
        .o_count2      (o2),
        .o_count3      (o3)
    );

    function automatic void push_exp(input logic [5:0] a, b, d);
        exp_t x;
        x.e1 = a; x.e2 = b; x.e3 = d;
        sb_q.push_back(x);
    endfunction

    task automatic set_btn(input logic [2:0] m);
        {c3, c2, c1} = m;
    endtask

    // One press: high one cycle, low for lo_cycles.
    task automatic pulse(input logic [2:0] m, input int lo_cycles);
        set_btn(m);
        @(negedge clk);
        set_btn(3'b000);
        repeat (lo_cycles) @(negedge clk);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        rst = 1'b1; vo = 1'b0; set_btn(3'b000);
        repeat (n) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset;
        do_reset(2);
        push_exp(0, 0, 0);
        e = sb_q.pop_front();
        checks++;
        if ({o1, o2, o3} !== {e.e1, e.e2, e.e3}) begin
            $display("FAIL reset_state got=%0d,%0d,%0d exp=%0d,%0d,%0d", o1, o2, o3, e.e1, e.e2, e.e3);
            failures++;
        end
    endtask

    task automatic test_sequence;
        logic [2:0] seq [8] = '{3'b001, 3'b010, 3'b001, 3'b100,
                                3'b010, 3'b010, 3'b001, 3'b100};
        do_reset(2);
        for (int i = 0; i < 8; i++) begin
            pulse(seq[i], 2);
            push_exp(0, 0, 0);
            e = sb_q.pop_front();
            checks++;
            if ({o1, o2, o3} !== {e.e1, e.e2, e.e3}) begin
                $display("FAIL hidden_while_voting[%0d] got=%0d,%0d,%0d exp=%0d,%0d,%0d", i, o1, o2, o3, e.e1, e.e2, e.e3);
                failures++;
            end
        end
        vo = 1'b1;
        push_exp(3, 3, 2);
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if ({o1, o2, o3} !== {e.e1, e.e2, e.e3}) begin
            $display("FAIL sequence_close got=%0d,%0d,%0d exp=%0d,%0d,%0d", o1, o2, o3, e.e1, e.e2, e.e3);
            failures++;
        end
    endtask

    // Runs right after test_sequence: poll closed with 3,3,2.
    task automatic test_frozen_then_reset;
        pulse(3'b001, 1);
        pulse(3'b001, 1);
        vo = 1'b0;
        repeat (2) @(negedge clk);
        push_exp(3, 3, 2);
        e = sb_q.pop_front();
        checks++;
        if ({o1, o2, o3} !== {e.e1, e.e2, e.e3}) begin
            $display("FAIL frozen_after_close got=%0d,%0d,%0d exp=%0d,%0d,%0d", o1, o2, o3, e.e1, e.e2, e.e3);
            failures++;
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        push_exp(0, 0, 0);
        e = sb_q.pop_front();
        checks++;
        if ({o1, o2, o3} !== {e.e1, e.e2, e.e3}) begin
            $display("FAIL reset_after_close got=%0d,%0d,%0d exp=%0d,%0d,%0d", o1, o2, o3, e.e1, e.e2, e.e3);
            failures++;
        end
        // Back in VOTING with cleared counters: one vote then close.
        pulse(3'b001, 2);
        vo = 1'b1;
        push_exp(1, 0, 0);
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if ({o1, o2, o3} !== {e.e1, e.e2, e.e3}) begin
            $display("FAIL voting_after_reset got=%0d,%0d,%0d exp=%0d,%0d,%0d", o1, o2, o3, e.e1, e.e2, e.e3);
            failures++;
        end
    endtask

    task automatic test_hold;
        do_reset(2);
        set_btn(3'b001);
        repeat (10) @(negedge clk);
        set_btn(3'b000);
        @(negedge clk);
        vo = 1'b1;
        push_exp(1, 0, 0);
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if ({o1, o2, o3} !== {e.e1, e.e2, e.e3}) begin
            $display("FAIL hold_one_vote got=%0d,%0d,%0d exp=%0d,%0d,%0d", o1, o2, o3, e.e1, e.e2, e.e3);
            failures++;
        end
    endtask

    task automatic test_invalid;
        do_reset(2);
        pulse(3'b011, 2);
        pulse(3'b100, 2);
        pulse(3'b111, 2);
        vo = 1'b1;
        push_exp(0, 0, 1);
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if ({o1, o2, o3} !== {e.e1, e.e2, e.e3}) begin
            $display("FAIL invalid_ballot got=%0d,%0d,%0d exp=%0d,%0d,%0d", o1, o2, o3, e.e1, e.e2, e.e3);
            failures++;
        end
    endtask

    task automatic test_saturate;
        do_reset(2);
        for (int i = 0; i < 70; i++) pulse(3'b010, 1);
        vo = 1'b1;
        push_exp(0, 63, 0);
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if ({o1, o2, o3} !== {e.e1, e.e2, e.e3}) begin
            $display("FAIL saturate got=%0d,%0d,%0d exp=%0d,%0d,%0d", o1, o2, o3, e.e1, e.e2, e.e3);
            failures++;
        end
    endtask

    task automatic test_press_on_close;
        do_reset(2);
        pulse(3'b001, 2);
        set_btn(3'b100);
        vo = 1'b1;
        push_exp(1, 0, 0);
        @(negedge clk);
        set_btn(3'b000);
        e = sb_q.pop_front();
        checks++;
        if ({o1, o2, o3} !== {e.e1, e.e2, e.e3}) begin
            $display("FAIL press_on_close got=%0d,%0d,%0d exp=%0d,%0d,%0d", o1, o2, o3, e.e1, e.e2, e.e3);
            failures++;
        end
    endtask

    // Button held through reset release counts once on the first normal edge.
    task automatic test_held_through_reset;
        @(negedge clk);
        rst = 1'b1; vo = 1'b0; set_btn(3'b100);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        set_btn(3'b000);
        @(negedge clk);
        vo = 1'b1;
        push_exp(0, 0, 1);
        @(negedge clk);
        e = sb_q.pop_front();
        checks++;
        if ({o1, o2, o3} !== {e.e1, e.e2, e.e3}) begin
            $display("FAIL held_through_reset got=%0d,%0d,%0d exp=%0d,%0d,%0d", o1, o2, o3, e.e1, e.e2, e.e3);
            failures++;
        end
    endtask

    initial begin
        rst = 1'b1; vo = 1'b0; c1 = 1'b0; c2 = 1'b0; c3 = 1'b0;
        test_reset;
        test_sequence;
        test_frozen_then_reset;
        test_hold;
        test_invalid;
        test_saturate;
        test_press_on_close;
        test_held_through_reset;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
